// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target with a memory-mapped CPU face.
// SCK, CSX and SDI are oversampled in the 25 MHz clk domain (2-FF sync plus a
// history FF for edge detection). Frames carry any number of MSB-first bytes.
// CPU side: `load` queues a 1-byte reply, `clear` pops a received byte, and
// `out` shows {no_data, tx_pending, overrun, 5'b0, head_byte}.
// Build option: define SPI_TARGET_RXFIFO_EN for a 4-entry rx FIFO; otherwise
// rx storage is a single holding register.

module spi_target (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        clear,
   input  logic [15:0] in,
   output logic [15:0] out,
   input  logic        SCK,
   input  logic        CSX,
   input  logic        SDI,
   output logic        SDO
);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;

   // Pin conditioning
   logic       r_sck_meta, r_sck_sync, r_sck_prev;
   logic       r_csx_meta, r_csx_sync, r_csx_prev;
   logic       r_sdi_meta, r_sdi_sync;

   // Protocol engine
   logic [0:0] r_state;
   logic [2:0] r_bitcnt;
   logic       r_reload;
   logic [7:0] r_rx_shift;
   logic [7:0] r_tx_shift;
   logic       r_sdo;

   // CPU-side state
   logic [7:0] r_tx_buf;
   logic       r_tx_pending;
   logic       r_overrun;

   logic       w_sck_rise, w_sck_fall;
   logic       w_csx_rise, w_csx_fall;
   logic [7:0] w_rx_byte;
   logic [7:0] w_tx_next;
   logic       w_push;
   logic       w_tx_consume;
   logic       w_pop;
   logic       w_full;
   logic       w_empty;
   logic       w_drop;
   logic       w_write;
   logic [7:0] w_head;
   logic       w_unused_in;

   // Only the low byte of the CPU word carries data.
   assign w_unused_in = ^in[15:8];

   // Two-stage synchronizers plus history FFs; reset to an idle bus (CSX high).
   // NOTE: every clocked block uses non-blocking assignments so all registers
   // update together from the values present before the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sck_meta <= 1'b0;
         r_sck_sync <= 1'b0;
         r_sck_prev <= 1'b0;
         r_csx_meta <= 1'b1;
         r_csx_sync <= 1'b1;
         r_csx_prev <= 1'b1;
         r_sdi_meta <= 1'b0;
         r_sdi_sync <= 1'b0;
      end else begin
         r_sck_meta <= SCK;
         r_sck_sync <= r_sck_meta;
         r_sck_prev <= r_sck_sync;
         r_csx_meta <= CSX;
         r_csx_sync <= r_csx_meta;
         r_csx_prev <= r_csx_sync;
         r_sdi_meta <= SDI;
         r_sdi_sync <= r_sdi_meta;
      end
   end

   assign w_sck_rise = r_sck_sync & ~r_sck_prev;
   assign w_sck_fall = ~r_sck_sync & r_sck_prev;
   assign w_csx_rise = r_csx_sync & ~r_csx_prev;
   assign w_csx_fall = ~r_csx_sync & r_csx_prev;

   // SDI is stable around the sampling SCK edge, so its synced value lines up
   // with the SCK edge detected in the same cycle.
   assign w_rx_byte = {r_rx_shift[6:0], r_sdi_sync};
   assign w_tx_next = r_tx_pending ? r_tx_buf : 8'hFF;

   // Decode the single-cycle events that cross into the CPU-side storage.
   // NOTE: each output gets a default first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      w_push       = 1'b0;
      w_tx_consume = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_csx_fall) w_tx_consume = 1'b1;
         end
         ST_ACTIVE: begin
            if (!w_csx_rise) begin
               if (w_sck_rise && (r_bitcnt == 3'd7)) w_push       = 1'b1;
               if (w_sck_fall && r_reload)           w_tx_consume = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Frame FSM: bit counting, rx/tx shifting and the per-byte tx reload.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_bitcnt   <= 3'd0;
         r_reload   <= 1'b0;
         r_rx_shift <= 8'h00;
         r_tx_shift <= 8'hFF;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_bitcnt <= 3'd0;
               r_reload <= 1'b0;
               if (w_csx_fall) begin
                  r_state    <= ST_ACTIVE;
                  r_tx_shift <= w_tx_next;
               end
            end
            ST_ACTIVE: begin
               if (w_csx_rise) begin
                  // Deselect wins over any coincident SCK edge; a partial
                  // byte and any reply already in the shifter are dropped.
                  r_state  <= ST_IDLE;
                  r_bitcnt <= 3'd0;
                  r_reload <= 1'b0;
               end else if (w_sck_rise) begin
                  r_rx_shift <= w_rx_byte;
                  r_bitcnt   <= r_bitcnt + 3'd1;
                  if (r_bitcnt == 3'd7) r_reload <= 1'b1;
               end else if (w_sck_fall) begin
                  if (r_reload) begin
                     r_tx_shift <= w_tx_next;
                     r_reload   <= 1'b0;
                  end else if (r_bitcnt != 3'd0) begin
                     r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Registered MISO: idles high, follows the shifter MSB while selected.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_sdo <= 1'b1;
      else       r_sdo <= (r_state == ST_ACTIVE) ? r_tx_shift[7] : 1'b1;
   end

   assign SDO = r_sdo;

   // Reply buffer: a load in the same cycle as a consume keeps the new byte
   // pending while the shifter takes the old one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tx_buf     <= 8'h00;
         r_tx_pending <= 1'b0;
      end else if (load) begin
         r_tx_buf     <= in[7:0];
         r_tx_pending <= 1'b1;
      end else if (w_tx_consume) begin
         r_tx_pending <= 1'b0;
      end
   end

   // Pop happens before push, so a simultaneous clear makes room for the byte.
   assign w_drop  = w_push & w_full & ~w_pop;
   assign w_write = w_push & ~w_drop;

`ifdef SPI_TARGET_RXFIFO_EN
   logic [7:0] r_fifo_mem [0:3];
   logic [1:0] r_wr_ptr;
   logic [1:0] r_rd_ptr;
   logic [2:0] r_count;

   assign w_pop   = clear & (r_count != 3'd0);
   assign w_full  = (r_count == 3'd4);
   assign w_empty = (r_count == 3'd0);
   assign w_head  = r_fifo_mem[r_rd_ptr];

   // FIFO storage array.
   // NOTE: the data array has no reset; the count and pointers alone decide
   // which entries are valid, so clearing the array would only cost logic.
   always_ff @(posedge clk) begin
      if (w_write) r_fifo_mem[r_wr_ptr] <= w_rx_byte;
   end

   // FIFO pointers and occupancy count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= 2'd0;
         r_rd_ptr <= 2'd0;
         r_count  <= 3'd0;
      end else begin
         if (w_write) r_wr_ptr <= r_wr_ptr + 2'd1;
         if (w_pop)   r_rd_ptr <= r_rd_ptr + 2'd1;
         case ({w_write, w_pop})
            2'b10:   r_count <= r_count + 3'd1;
            2'b01:   r_count <= r_count - 3'd1;
            default: r_count <= r_count;
         endcase
      end
   end
`else
   logic [7:0] r_hold_data;
   logic       r_hold_valid;

   assign w_pop   = clear & r_hold_valid;
   assign w_full  = r_hold_valid;
   assign w_empty = ~r_hold_valid;
   assign w_head  = r_hold_data;

   // Single holding register with a valid bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hold_data  <= 8'h00;
         r_hold_valid <= 1'b0;
      end else if (w_write) begin
         r_hold_data  <= w_rx_byte;
         r_hold_valid <= 1'b1;
      end else if (w_pop) begin
         r_hold_valid <= 1'b0;
      end
   end
`endif

   // Sticky overrun: set by a dropped byte, cleared by the CPU's clear strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       r_overrun <= 1'b0;
      else if (w_drop) r_overrun <= 1'b1;
      else if (clear)  r_overrun <= 1'b0;
   end

   assign out = {w_empty, r_tx_pending, r_overrun, 5'b00000,
                 (w_empty ? 8'h00 : w_head)};

endmodule
